// File: rtl/prim_gf_inv.sv
// prim_gf_inv: iterative multiplicative inverter over GF(2^Width).
//
// Computes a^-1 = a^(2^Width - 2) by Fermat square-and-multiply. One shared
// shift-and-reduce multiplier performs one squaring or one multiplication
// per cycle. Zero in gives zero out; there is no error flag.
//
// Optional feature macro: PRIM_GF_INV_DIV_EN
//   defined   -> a final multiply by the captured dividend is added, so the
//                result is operand_b_i * operand_a_i^-1 (one extra cycle).
//   undefined -> the result is operand_a_i^-1 and operand_b_i is unused.
//
// Parameters:
//   Width  field degree (>= 2)
//   IPoly  low Width bits of the irreducible polynomial (x^Width implicit)
//
// Ports:
//   clk_i        clock
//   rst_ni       asynchronous active-low reset
//   req_i        start request, sampled only while idle
//   operand_a_i  value to invert, captured on acceptance
//   operand_b_i  dividend, captured with operand_a_i (divide mode only)
//   busy_o       high while squaring/multiplying
//   ack_o        one-cycle pulse, inv_o valid
//   inv_o        result register, held until the next ack_o

module prim_gf_inv #(
    parameter int unsigned      Width = 32,
    parameter logic [Width-1:0] IPoly = Width'(32'h0000_8299)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_i,
    input  logic [Width-1:0] operand_a_i,
    input  logic [Width-1:0] operand_b_i,
    output logic             busy_o,
    output logic             ack_o,
    output logic [Width-1:0] inv_o
);

    localparam int unsigned CntW = $clog2(Width);

`ifdef PRIM_GF_INV_DIV_EN
    localparam int unsigned StateW = 3;
`else
    localparam int unsigned StateW = 2;
`endif

    typedef enum logic [StateW-1:0] {
        ST_IDLE = StateW'(0),
        ST_SQR  = StateW'(1),
        ST_MUL  = StateW'(2),
        ST_DONE = StateW'(3)
`ifdef PRIM_GF_INV_DIV_EN
        ,
        ST_FIN  = StateW'(4)
`endif
    } state_e;

    // Field multiply: shift-and-reduce of x, accumulated over the set bits of y.
    function automatic logic [Width-1:0] gf_mul(input logic [Width-1:0] x,
                                                input logic [Width-1:0] y);
        logic [Width-1:0] prod;
        logic [Width-1:0] term;
        prod = '0;
        term = x;
        for (int unsigned i = 0; i < Width; i++) begin
            if (y[i]) begin
                prod = prod ^ term;
            end
            term = term[Width-1] ? ((term << 1) ^ IPoly) : (term << 1);
        end
        return prod;
    endfunction

    state_e           state_q, state_d;
    logic [Width-1:0] sq_q, sq_d;
    logic [Width-1:0] acc_q, acc_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [Width-1:0] inv_q, inv_d;
    logic             ack_q, ack_d;
    logic             busy_q, busy_d;

    logic [Width-1:0] mul_x_c;
    logic [Width-1:0] mul_y_c;
    logic [Width-1:0] mul_res_c;

`ifdef PRIM_GF_INV_DIV_EN
    logic [Width-1:0] b_q, b_d;
`else
    // Dividend has no consumer without the divide stage.
    logic unused_operand_b;
    assign unused_operand_b = ^operand_b_i;
`endif

    // Operand mux into the shared multiplier.
    always_comb begin
        mul_x_c = sq_q;
        mul_y_c = sq_q;
        unique case (state_q)
            ST_MUL: begin
                mul_x_c = acc_q;
                mul_y_c = sq_q;
            end
`ifdef PRIM_GF_INV_DIV_EN
            ST_FIN: begin
                mul_x_c = acc_q;
                mul_y_c = b_q;
            end
`endif
            default: begin
                mul_x_c = sq_q;
                mul_y_c = sq_q;
            end
        endcase
    end

    assign mul_res_c = gf_mul(mul_x_c, mul_y_c);

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        sq_d    = sq_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        inv_d   = inv_q;
`ifdef PRIM_GF_INV_DIV_EN
        b_d     = b_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (req_i) begin
                    sq_d    = operand_a_i;
                    acc_d   = Width'(1);
                    cnt_d   = CntW'(1);
`ifdef PRIM_GF_INV_DIV_EN
                    b_d     = operand_b_i;
`endif
                    state_d = ST_SQR;
                end
            end
            ST_SQR: begin
                sq_d    = mul_res_c;
                state_d = ST_MUL;
            end
            ST_MUL: begin
                // After k passes acc holds a^(2^(k+1)-2); Width-1 passes give a^-1.
                acc_d = mul_res_c;
                if (cnt_q == CntW'(Width - 1)) begin
`ifdef PRIM_GF_INV_DIV_EN
                    state_d = ST_FIN;
`else
                    inv_d   = mul_res_c;
                    state_d = ST_DONE;
`endif
                end else begin
                    cnt_d   = cnt_q + CntW'(1);
                    state_d = ST_SQR;
                end
            end
`ifdef PRIM_GF_INV_DIV_EN
            ST_FIN: begin
                acc_d   = mul_res_c;
                inv_d   = mul_res_c;
                state_d = ST_DONE;
            end
`endif
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_comb begin
        ack_d  = (state_d == ST_DONE);
        busy_d = (state_d != ST_IDLE) && (state_d != ST_DONE);
    end

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            sq_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            inv_q   <= '0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sq_q    <= sq_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            inv_q   <= inv_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
        end
    end

`ifdef PRIM_GF_INV_DIV_EN
    // Captured dividend.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            b_q <= '0;
        end else begin
            b_q <= b_d;
        end
    end
`endif

    assign busy_o = busy_q;
    assign ack_o  = ack_q;
    assign inv_o  = inv_q;

endmodule

// File: tb/tb_prim_gf_inv.sv
// Directed bench for prim_gf_inv in the AES field (Width 8, poly 0x11B).
module tb_prim_gf_inv;

    localparam int unsigned W    = 8;
    localparam logic [7:0]  POLY = 8'h1B;
`ifdef PRIM_GF_INV_DIV_EN
    localparam int Lat = 15;
`else
    localparam int Lat = 14;
`endif
    localparam int Gap = Lat + 2;

    logic         clk;
    logic         rst_n;
    logic         req;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         busy;
    logic         ack;
    logic [W-1:0] inv;

    int n_tests = 0;
    int n_fail  = 0;

    prim_gf_inv #(
        .Width (W),
        .IPoly (POLY)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_i       (req),
        .operand_a_i (op_a),
        .operand_b_i (op_b),
        .busy_o      (busy),
        .ack_o       (ack),
        .inv_o       (inv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference multiply: carry-less product, then reduce mod x^8+x^4+x^3+x+1.
    function automatic logic [7:0] ref_mul(input logic [7:0] x, input logic [7:0] y);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) begin
            if (y[i]) p = p ^ (15'(x) << i);
        end
        for (int i = 14; i >= 8; i--) begin
            if (p[i]) p = p ^ (15'(9'h11B) << (i - 8));
        end
        return p[7:0];
    endfunction

    // One transaction; optionally pulses req while busy.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input bit pulse,
                          output logic [7:0] res, output int lat, output int bsy,
                          output logic ack_after);
        @(negedge clk);
        op_a = a;
        op_b = b;
        req  = 1'b1;
        @(posedge clk);
        #1;
        req = 1'b0;
        lat = 0;
        bsy = busy ? 1 : 0;
        while (!ack && lat < 100) begin
            if (pulse) req = (lat == 2 || lat == 6 || lat == 9);
            @(posedge clk);
            #1;
            lat++;
            if (busy) bsy++;
        end
        req = 1'b0;
        res = inv;
        @(posedge clk);
        #1;
        ack_after = ack;
    endtask

    logic [7:0] res;
    int         lat;
    int         bsy;
    logic       ack_after;

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        req   = 1'b0;
        op_a  = '0;
        op_b  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ack", ack, 0);
        check("rst_busy", busy, 0);
        check("rst_inv", inv, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic inverse, 0x53 -> 0xCA, plus timing.
        run_op(8'h53, 8'h01, 1'b0, res, lat, bsy, ack_after);
        check("inv_53", res, 8'hCA);
        check("lat_53", lat, Lat);
        check("busy_53", bsy, Lat);
        check("ackw_53", ack_after, 0);

        run_op(8'h01, 8'h01, 1'b0, res, lat, bsy, ack_after);
        check("inv_01", res, 8'h01);
        run_op(8'h02, 8'h01, 1'b0, res, lat, bsy, ack_after);
        check("inv_02", res, 8'h8D);
        run_op(8'h00, 8'h01, 1'b0, res, lat, bsy, ack_after);
        check("inv_00", res, 8'h00);
        check("lat_00", lat, Lat);

`ifdef PRIM_GF_INV_DIV_EN
        run_op(8'h53, 8'h02, 1'b0, res, lat, bsy, ack_after);
        check("div_53_02", res, 8'h8F);
        check("div_lat", lat, Lat);
        run_op(8'h53, 8'h53, 1'b0, res, lat, bsy, ack_after);
        check("div_53_53", res, 8'h01);
        run_op(8'h00, 8'h53, 1'b0, res, lat, bsy, ack_after);
        check("div_00_53", res, 8'h00);
`else
        // Dividend must have no effect without the divide stage.
        run_op(8'h53, 8'h02, 1'b0, res, lat, bsy, ack_after);
        check("b_ignored", res, 8'hCA);
`endif

        // Requests pulsed while busy change neither result nor timing.
        run_op(8'h53, 8'h01, 1'b1, res, lat, bsy, ack_after);
        check("pulse_inv", res, 8'hCA);
        check("pulse_lat", lat, Lat);
        check("pulse_ackw", ack_after, 0);

        // Full sweep: a * a^-1 must be 1.
        for (int a = 1; a < 256; a++) begin
            run_op(8'(a), 8'h01, 1'b0, res, lat, bsy, ack_after);
            check($sformatf("sweep_%02h", a), ref_mul(8'(a), res), 8'h01);
            check($sformatf("sweep_lat_%02h", a), lat, Lat);
        end

        // Asynchronous reset mid-operation.
        @(negedge clk);
        op_a = 8'h53;
        op_b = 8'h01;
        req  = 1'b1;
        @(posedge clk);
        #1;
        req = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        check("busy_pre_rst", busy, 1);
        rst_n = 1'b0;
        #1;
        check("arst_ack", ack, 0);
        check("arst_busy", busy, 0);
        check("arst_inv", inv, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(8'h02, 8'h01, 1'b0, res, lat, bsy, ack_after);
        check("post_rst_inv", res, 8'h8D);
        check("post_rst_lat", lat, Lat);

        // Request held high: back-to-back results.
        begin
            int   last;
            int   npulse;
            logic prev;
            last   = -1;
            npulse = 0;
            prev   = 1'b0;
            @(negedge clk);
            op_a = 8'h53;
            op_b = 8'h01;
            req  = 1'b1;
            for (int c = 0; c < 80; c++) begin
                @(posedge clk);
                #1;
                if (prev) check("b2b_width", ack, 0);
                if (ack) begin
                    check("b2b_inv", inv, 8'hCA);
                    if (last >= 0) check("b2b_gap", c - last, Gap);
                    else           check("b2b_first", c, Lat);
                    last = c;
                    npulse++;
                end
                prev = ack;
            end
            req = 1'b0;
            check("b2b_count", npulse, (79 - Lat) / Gap + 1);
            repeat (40) @(posedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
